fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of first fetch after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 imem_req  out  1  instruction-memory request valid.
REQ-005 imem_addr  out  32  byte address of the outstanding request, word aligned.
REQ-006 imem_ack  in  1  memory returns imem_rdata this cycle; completes the request.
REQ-007 imem_rdata  in  32  fetched instruction word, sampled only when imem_ack=1.
REQ-008 redirect  in  1  branch/jump taken; fetch restarts at redirect_pc.
REQ-009 redirect_pc  in  32  redirect target; bits [1:0] SHALL be forced to 0 internally.
REQ-010 inst_ready  in  1  decode stage accepts the held instruction this cycle.
REQ-011 inst_valid  out  1  instruction/inst_pc/pc_plus4 are valid.
REQ-012 instruction  out  32  registered instruction word handed to decode.
REQ-013 inst_pc  out  32  address the instruction was fetched from.
REQ-014 pc_plus4  out  32  inst_pc + 4 (link value for JAL/JALR), modulo 2^32.

Function
REQ-015 FSM states SHALL be FETCH, HOLD and DRAIN. Registers: pc (next fetch address) and fetch_addr (address of the outstanding request).
REQ-016 FETCH: imem_req=1, imem_addr=fetch_addr=pc; req and addr SHALL stay stable until imem_ack.
REQ-017 FETCH and imem_ack without redirect: next cycle instruction=imem_rdata, inst_pc=fetch_addr, inst_valid=1, pc=pc+4, state=HOLD.
REQ-018 HOLD: imem_req=0; outputs held stable while inst_valid=1 and inst_ready=0.
REQ-019 HOLD and inst_ready=1 without redirect: next cycle inst_valid=0, state=FETCH; latency ack->valid 1 cycle; max throughput one instruction per 2 cycles with a 1-cycle-ack memory.
REQ-020 redirect SHALL have priority over every other event in every state; next cycle inst_valid=0 and pc=redirect_pc.
REQ-021 redirect in HOLD, or in FETCH with imem_ack=1 the same cycle: returned data discarded, next state FETCH.
REQ-022 redirect in FETCH without imem_ack: next state DRAIN.
REQ-023 DRAIN: imem_req=1 with the stale fetch_addr until imem_ack. Returned data discarded. Next state FETCH with fetch_addr=pc.
REQ-024 redirect during DRAIN SHALL overwrite pc; the state remains DRAIN.
REQ-025 inst_ready while inst_valid=0 SHALL be ignored.
REQ-026 pc increment wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no overflow flag.

Reset
REQ-027 While rst=1: state=FETCH, pc=fetch_addr=RESET_PC, imem_req=0, inst_valid=0, instruction=32'h0000_0013 (NOP), inst_pc=0, pc_plus4=4.
REQ-028 imem_req SHALL first assert in the cycle after rst deasserts.
REQ-029 rst mid-request SHALL drop imem_req immediately. The memory shall abandon the request; a late imem_ack SHALL be ignored until imem_req is reasserted.

Structure
REQ-030 Shared package: FSM state encoding, RESET_PC default, XLEN=32, NOP constant 32'h0000_0013, instruction-width constant.
REQ-031 One sub-module, fetch_pc_reg, SHALL hold pc with the rules hold/+4/redirect-load/reset. All other logic is flat inside fetch_stage.

Verification
REQ-032 Reset release with 1-cycle ack memory and inst_ready tied to 1: fetch addresses 0,4,8,12. inst_valid pulses every 2nd cycle with inst_pc 0,4,8 and pc_plus4 4,8,12.
REQ-033 inst_ready=0 for 5 cycles after first valid: instruction/inst_pc held, imem_req=0. After inst_ready=1, the next fetch is at addr 4.
REQ-034 3-cycle ack latency and redirect to 32'h100 in the 2nd wait cycle: state DRAIN, imem_addr stays at the old addr until ack, data discarded. The next request is at 32'h100.
REQ-035 redirect_pc=32'h203 in HOLD: inst_valid drops next cycle, next imem_addr=32'h200.
REQ-036 redirect coinciding with imem_ack in FETCH: the acked word never appears on instruction. The next fetch is at the target.
REQ-037 pc=32'hFFFF_FFFC fetched via redirect: inst_pc=32'hFFFF_FFFC, pc_plus4=0, next fetch addr=0. rst mid-DRAIN: imem_req=0 next cycle, the first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INSN         = 32'h0000_0013;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset, redirect load, +4 increment or hold.
module fetch_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Load wins over increment; the increment wraps naturally at 2^32.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = {load_pc_i[XLEN-1:2], 2'b00};
        end else if (inc_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = rst ? RESET_PC : pc_d;

endmodule

// File: rtl/fetch_stage.sv
// Single-outstanding-request fetch stage with a one-entry output holding register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            inst_ready,
    output logic            inst_valid,
    output logic [ILEN-1:0] instruction,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] pc_plus4
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic            valid_q, valid_d;
    logic [ILEN-1:0] insn_q, insn_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            req_en_q;
    logic            ack_vld;
    logic            pc_inc;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (pc_inc),
        .load_i    (redirect),
        .load_pc_i (redirect_pc),
        .pc_o      (pc),
        .pc_next_o (pc_next)
    );

    // Request is held off for one cycle after reset and drops combinationally on reset.
    assign imem_req = req_en_q & ~rst & (state_q != StHold);
    assign ack_vld  = imem_ack & imem_req;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        insn_d  = insn_q;
        ipc_d   = ipc_q;
        pc_inc  = 1'b0;
        if (redirect) begin
            valid_d = 1'b0;
        end
        case (state_q)
            StFetch: begin
                if (redirect) begin
                    state_d = ack_vld ? StFetch : StDrain;
                end else if (ack_vld) begin
                    state_d = StHold;
                    valid_d = 1'b1;
                    insn_d  = imem_rdata;
                    ipc_d   = fetch_addr_q;
                    pc_inc  = 1'b1;
                end
            end
            StHold: begin
                if (redirect || (inst_ready && valid_q)) begin
                    state_d = StFetch;
                    valid_d = 1'b0;
                end
            end
            StDrain: begin
                // A redirect only retargets pc; the stale request must still complete.
                if (ack_vld) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    assign fetch_addr_d = (state_d == StFetch) ? pc_next : fetch_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFetch;
            fetch_addr_q <= RESET_PC;
            valid_q      <= 1'b0;
            insn_q       <= NOP_INSN;
            ipc_q        <= '0;
            req_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            valid_q      <= valid_d;
            insn_q       <= insn_d;
            ipc_q        <= ipc_d;
            req_en_q     <= 1'b1;
        end
    end

    assign imem_addr   = fetch_addr_q;
    assign inst_valid  = valid_q;
    assign instruction = insn_q;
    assign inst_pc     = ipc_q;
    assign pc_plus4    = ipc_q + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: cycle-by-cycle table plus a free-running throughput run.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_ready  (inst_ready),
        .inst_valid  (inst_valid),
        .instruction (instruction),
        .inst_pc     (inst_pc),
        .pc_plus4    (pc_plus4)
    );

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_ins;
        logic [31:0] e_ipc;
        logic [31:0] e_pc4;
    } vec_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic void add(input logic r, input logic a, input logic [31:0] rd,
                                input logic rr, input logic [31:0] rp, input logic ry,
                                input logic q, input logic [31:0] ad, input logic v,
                                input logic [31:0] ins, input logic [31:0] ip,
                                input logic [31:0] p4);
        vec_t t;
        t.rst = r;  t.ack = a;  t.rdata = rd; t.redir = rr; t.rpc = rp; t.rdy = ry;
        t.e_req = q; t.e_addr = ad; t.e_vld = v; t.e_ins = ins; t.e_ipc = ip; t.e_pc4 = p4;
        vecs.push_back(t);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin
        // Reset state, then ack-in-1 with ready=1: fetches 0,4,8,12
        add(1, 0, 0, 0, 0, 1,  0, 0, 0, NOP, 0, 4);
        add(0, 0, 0, 0, 0, 1,  0, 0, 0, NOP, 0, 4);
        add(0, 1, 32'hD000_0000, 0, 0, 1,  1, 0, 0, NOP, 0, 4);
        add(0, 0, 0, 0, 0, 1,  0, 0, 1, 32'hD000_0000, 0, 4);
        add(0, 1, 32'hD000_0004, 0, 0, 1,  1, 4, 0, 32'hD000_0000, 0, 4);
        add(0, 0, 0, 0, 0, 1,  0, 4, 1, 32'hD000_0004, 4, 8);
        add(0, 1, 32'hD000_0008, 0, 0, 1,  1, 8, 0, 32'hD000_0004, 4, 8);
        add(0, 0, 0, 0, 0, 1,  0, 8, 1, 32'hD000_0008, 8, 12);
        add(0, 0, 0, 0, 0, 0,  1, 12, 0, 32'hD000_0008, 8, 12);
        // Backpressure: five cycles of inst_ready=0, output held, no request
        add(0, 1, 32'hD000_000C, 0, 0, 0,  1, 12, 0, 32'hD000_0008, 8, 12);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0,  0, 12, 1, 32'hD000_000C, 12, 16);
        add(0, 0, 0, 0, 0, 1,  0, 12, 1, 32'hD000_000C, 12, 16);
        add(0, 0, 0, 0, 0, 0,  1, 16, 0, 32'hD000_000C, 12, 16);
        // Slow memory, redirect to 0x100 in the 2nd wait cycle: drain stale request
        add(0, 0, 0, 1, 32'h100, 0,  1, 16, 0, 32'hD000_000C, 12, 16);
        add(0, 0, 0, 0, 0, 0,  1, 16, 0, 32'hD000_000C, 12, 16);
        add(0, 1, 32'hDEAD_BEEF, 0, 0, 0,  1, 16, 0, 32'hD000_000C, 12, 16);
        add(0, 0, 0, 0, 0, 0,  1, 32'h100, 0, 32'hD000_000C, 12, 16);
        add(0, 1, 32'hD000_0100, 0, 0, 0,  1, 32'h100, 0, 32'hD000_000C, 12, 16);
        add(0, 0, 0, 0, 0, 0,  0, 32'h100, 1, 32'hD000_0100, 32'h100, 32'h104);
        // Misaligned redirect in HOLD
        add(0, 0, 0, 1, 32'h203, 0,  0, 32'h100, 1, 32'hD000_0100, 32'h100, 32'h104);
        add(0, 0, 0, 0, 0, 0,  1, 32'h200, 0, 32'hD000_0100, 32'h100, 32'h104);
        // Redirect coinciding with ack: word discarded
        add(0, 1, 32'hBAD0_BAD0, 1, 32'h300, 0,  1, 32'h200, 0, 32'hD000_0100, 32'h100, 32'h104);
        add(0, 0, 0, 0, 0, 0,  1, 32'h300, 0, 32'hD000_0100, 32'h100, 32'h104);
        add(0, 1, 32'hD000_0300, 0, 0, 0,  1, 32'h300, 0, 32'hD000_0100, 32'h100, 32'h104);
        add(0, 0, 0, 0, 0, 1,  0, 32'h300, 1, 32'hD000_0300, 32'h300, 32'h304);
        // Wrap at top of address space
        add(0, 0, 0, 1, 32'hFFFF_FFFC, 0,  1, 32'h304, 0, 32'hD000_0300, 32'h300, 32'h304);
        add(0, 1, 0, 0, 0, 0,  1, 32'h304, 0, 32'hD000_0300, 32'h300, 32'h304);
        add(0, 1, 32'hEEEE_EEEE, 0, 0, 0,  1, 32'hFFFF_FFFC, 0, 32'hD000_0300, 32'h300, 32'h304);
        add(0, 0, 0, 0, 0, 1,  0, 32'hFFFF_FFFC, 1, 32'hEEEE_EEEE, 32'hFFFF_FFFC, 0);
        add(0, 0, 0, 0, 0, 0,  1, 0, 0, 32'hEEEE_EEEE, 32'hFFFF_FFFC, 0);
        // Reset in the middle of a drain; late ack ignored
        add(0, 0, 0, 1, 32'h400, 0,  1, 0, 0, 32'hEEEE_EEEE, 32'hFFFF_FFFC, 0);
        add(0, 0, 0, 0, 0, 0,  1, 0, 0, 32'hEEEE_EEEE, 32'hFFFF_FFFC, 0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 32'hEEEE_EEEE, 32'hFFFF_FFFC, 0);
        add(0, 1, 32'h5555_5555, 0, 0, 0,  0, 0, 0, NOP, 0, 4);
        add(0, 0, 0, 0, 0, 0,  1, 0, 0, NOP, 0, 4);

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
            redirect = vecs[i].redir; redirect_pc = vecs[i].rpc; inst_ready = vecs[i].rdy;
            #1;
            n_vec++;
            if ({imem_req, imem_addr, inst_valid, instruction, inst_pc, pc_plus4} !==
                {vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld, vecs[i].e_ins,
                 vecs[i].e_ipc, vecs[i].e_pc4}) begin
                n_fail++;
                $display("FAIL vec %0d: got req=%b addr=%h vld=%b ins=%h ipc=%h pc4=%h expected req=%b addr=%h vld=%b ins=%h ipc=%h pc4=%h",
                         i, imem_req, imem_addr, inst_valid, instruction, inst_pc, pc_plus4,
                         vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld, vecs[i].e_ins,
                         vecs[i].e_ipc, vecs[i].e_pc4);
            end
        end

        // Free-running: 1-cycle-ack memory, ready tied high, one instruction per 2 cycles
        begin
            logic [31:0] addrs[$];
            logic [31:0] ipcs[$];
            int          vcyc[$];
            @(negedge clk);
            rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 30 && addrs.size() < 4; c++) begin
                #1;
                if (inst_valid) begin
                    ipcs.push_back(inst_pc);
                    vcyc.push_back(c);
                    check("tp pc_plus4", pc_plus4, inst_pc + 32'd4);
                    check("tp insn", instruction, 32'hC000_0000 | inst_pc);
                end
                imem_ack   = imem_req;
                imem_rdata = 32'hC000_0000 | imem_addr;
                if (imem_req) addrs.push_back(imem_addr);
                @(negedge clk);
            end
            imem_ack = 1'b0;
            check("tp fetch count", addrs.size(), 4);
            check("tp valid count", ipcs.size(), 3);
            for (int k = 0; k < addrs.size() && k < 4; k++) check("tp fetch addr", addrs[k], k * 4);
            for (int k = 0; k < ipcs.size() && k < 3; k++) check("tp inst_pc", ipcs[k], k * 4);
            for (int k = 1; k < vcyc.size(); k++) check("tp valid spacing", vcyc[k] - vcyc[k-1], 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
